// File: rtl/priority_encoder_16by4_case.sv
// Purpose: 16-to-4 priority encoder; MSB_PRIORITY selects highest or lowest set index as winner.
// Latency: 1 cycle, with data_out and valid both registered from a combinational casez decode.
// Backpressure: none; a new data_in value is accepted on every rising clk edge.
module priority_encoder_16by4_case #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    output logic [3:0]  data_out,
    output logic        valid
);

    logic [3:0] enc_idx;
    logic       enc_any;

    generate
        if (MSB_PRIORITY) begin : g_msb
            always_comb begin
                enc_idx = 4'd0;
                enc_any = 1'b1;
                casez (data_in)
                    16'b1???????????????: enc_idx = 4'd15;
                    16'b01??????????????: enc_idx = 4'd14;
                    16'b001?????????????: enc_idx = 4'd13;
                    16'b0001????????????: enc_idx = 4'd12;
                    16'b00001???????????: enc_idx = 4'd11;
                    16'b000001??????????: enc_idx = 4'd10;
                    16'b0000001?????????: enc_idx = 4'd9;
                    16'b00000001????????: enc_idx = 4'd8;
                    16'b000000001???????: enc_idx = 4'd7;
                    16'b0000000001??????: enc_idx = 4'd6;
                    16'b00000000001?????: enc_idx = 4'd5;
                    16'b000000000001????: enc_idx = 4'd4;
                    16'b0000000000001???: enc_idx = 4'd3;
                    16'b00000000000001??: enc_idx = 4'd2;
                    16'b000000000000001?: enc_idx = 4'd1;
                    16'b0000000000000001: enc_idx = 4'd0;
                    // Only the all-zero vector lands here.
                    default: begin
                        enc_idx = 4'd0;
                        enc_any = 1'b0;
                    end
                endcase
            end
        end else begin : g_lsb
            always_comb begin
                enc_idx = 4'd0;
                enc_any = 1'b1;
                casez (data_in)
                    16'b???????????????1: enc_idx = 4'd0;
                    16'b??????????????10: enc_idx = 4'd1;
                    16'b?????????????100: enc_idx = 4'd2;
                    16'b????????????1000: enc_idx = 4'd3;
                    16'b???????????10000: enc_idx = 4'd4;
                    16'b??????????100000: enc_idx = 4'd5;
                    16'b?????????1000000: enc_idx = 4'd6;
                    16'b????????10000000: enc_idx = 4'd7;
                    16'b???????100000000: enc_idx = 4'd8;
                    16'b??????1000000000: enc_idx = 4'd9;
                    16'b?????10000000000: enc_idx = 4'd10;
                    16'b????100000000000: enc_idx = 4'd11;
                    16'b???1000000000000: enc_idx = 4'd12;
                    16'b??10000000000000: enc_idx = 4'd13;
                    16'b?100000000000000: enc_idx = 4'd14;
                    16'b1000000000000000: enc_idx = 4'd15;
                    default: begin
                        enc_idx = 4'd0;
                        enc_any = 1'b0;
                    end
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= 4'd0;
            valid    <= 1'b0;
        end else begin
            data_out <= enc_idx;
            valid    <= enc_any;
        end
    end

endmodule

// File: tb/tb_priority_encoder_16by4_case.sv
// Directed and exhaustive checks of the 16-to-4 priority encoder in both priority modes.
module tb_priority_encoder_16by4_case;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  msb_out;
    logic        msb_vld;
    logic [3:0]  lsb_out;
    logic        lsb_vld;

    int n_checks;
    int n_fail;

    priority_encoder_16by4_case #(.MSB_PRIORITY(1'b1)) u_msb (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (msb_out),
        .valid    (msb_vld)
    );

    priority_encoder_16by4_case #(.MSB_PRIORITY(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (lsb_out),
        .valid    (lsb_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_msb(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [3:0] ref_lsb(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        data_in = 16'hFFFF;
        #3;
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_msb got %0d/%b want 0/0", msb_out, msb_vld);
        end
        n_checks++;
        if (lsb_out !== 4'd0 || lsb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_lsb got %0d/%b want 0/0", lsb_out, lsb_vld);
        end
        step();
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held_edge got %0d/%b want 0/0", msb_out, msb_vld);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (msb_out !== 4'd15 || msb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_msb got %0d/%b want 15/1", msb_out, msb_vld);
        end
        n_checks++;
        if (lsb_out !== 4'd0 || lsb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_lsb got %0d/%b want 0/1", lsb_out, lsb_vld);
        end
    endtask

    task automatic test_zero_vs_bit0();
        data_in = 16'h0000;
        step();
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b0 || lsb_out !== 4'd0 || lsb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_input got msb %0d/%b lsb %0d/%b want 0/0 0/0",
                     msb_out, msb_vld, lsb_out, lsb_vld);
        end
        data_in = 16'h0001;
        step();
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b1 || lsb_out !== 4'd0 || lsb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL bit0_input got msb %0d/%b lsb %0d/%b want 0/1 0/1",
                     msb_out, msb_vld, lsb_out, lsb_vld);
        end
    endtask

    task automatic test_one_hot();
        for (int i = 0; i < 16; i++) begin
            data_in = 16'd1 << i;
            step();
            n_checks++;
            if (msb_out !== 4'(i) || msb_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL one_hot_msb bit %0d got %0d/%b want %0d/1", i, msb_out, msb_vld, i);
            end
            n_checks++;
            if (lsb_out !== 4'(i) || lsb_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL one_hot_lsb bit %0d got %0d/%b want %0d/1", i, lsb_out, lsb_vld, i);
            end
        end
    endtask

    task automatic test_multi_bit();
        logic [15:0] vec [4];
        logic [3:0]  exp_m [4];
        logic [3:0]  exp_l [4];
        vec[0] = 16'h8001; exp_m[0] = 4'd15; exp_l[0] = 4'd0;
        vec[1] = 16'h0410; exp_m[1] = 4'd10; exp_l[1] = 4'd4;
        vec[2] = 16'h7FFE; exp_m[2] = 4'd14; exp_l[2] = 4'd1;
        vec[3] = 16'h1240; exp_m[3] = 4'd12; exp_l[3] = 4'd6;
        for (int k = 0; k < 4; k++) begin
            data_in = vec[k];
            step();
            n_checks++;
            if (msb_out !== exp_m[k] || msb_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_msb %h got %0d/%b want %0d/1", vec[k], msb_out, msb_vld, exp_m[k]);
            end
            n_checks++;
            if (lsb_out !== exp_l[k] || lsb_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_lsb %h got %0d/%b want %0d/1", vec[k], lsb_out, lsb_vld, exp_l[k]);
            end
        end
    endtask

    task automatic test_sampling();
        data_in = 16'h0410;
        step();
        #1 data_in = 16'hFFFF;
        #2;
        n_checks++;
        if (msb_out !== 4'd10 || lsb_out !== 4'd4 || msb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cycle_change got msb %0d lsb %0d vld %b want 10 4 1",
                     msb_out, lsb_out, msb_vld);
        end
        data_in = 16'h0000;
        #1;
        n_checks++;
        if (msb_out !== 4'd10 || msb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cycle_zero got %0d/%b want 10/1", msb_out, msb_vld);
        end
        step();
        n_checks++;
        if (msb_vld !== 1'b0 || msb_out !== 4'd0) begin
            n_fail++;
            $display("FAIL edge_sample_zero got %0d/%b want 0/0", msb_out, msb_vld);
        end
    endtask

    task automatic test_exhaustive();
        logic [15:0] v;
        int          mism;
        mism = 0;
        for (int n = 0; n < 65536; n++) begin
            v       = 16'(n);
            data_in = v;
            step();
            n_checks++;
            if (msb_out !== ref_msb(v) || msb_vld !== (v != 16'h0) ||
                lsb_out !== ref_lsb(v) || lsb_vld !== (v != 16'h0)) begin
                n_fail++;
                mism++;
                if (mism <= 10)
                    $display("FAIL sweep %h got msb %0d/%b lsb %0d/%b want %0d/%b %0d/%b",
                             v, msb_out, msb_vld, lsb_out, lsb_vld,
                             ref_msb(v), (v != 16'h0), ref_lsb(v), (v != 16'h0));
            end
        end
    endtask

    task automatic test_async_reset();
        data_in = 16'h1000;
        step();
        n_checks++;
        if (msb_out !== 4'd12 || msb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got %0d/%b want 12/1", msb_out, msb_vld);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b0 || lsb_out !== 4'd0 || lsb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear got msb %0d/%b lsb %0d/%b want 0/0 0/0",
                     msb_out, msb_vld, lsb_out, lsb_vld);
        end
        step();
        #1 rst = 1'b0;
        #2;
        n_checks++;
        if (msb_out !== 4'd0 || msb_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_release got %0d/%b want 0/0", msb_out, msb_vld);
        end
        step();
        n_checks++;
        if (msb_out !== 4'd12 || msb_vld !== 1'b1 || lsb_out !== 4'd12 || lsb_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge_after_reset got msb %0d/%b lsb %0d/%b want 12/1 12/1",
                     msb_out, msb_vld, lsb_out, lsb_vld);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        data_in  = 16'h0000;
        test_reset();
        test_zero_vs_bit0();
        test_one_hot();
        test_multi_bit();
        test_sampling();
        test_async_reset();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder_16by4_case.md
PRIORITY_ENCODER_16BY4_CASE -- requirements
Module: priority_encoder_16by4_case

Interface
REQ-001 The block SHALL expose parameter MSB_PRIORITY, default 1: 1 means the highest set index wins, 0 means the lowest set index wins.
REQ-002 The block SHALL expose port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL expose port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL expose port data_in, input, 16 bits: request vector; bit i is request i.
REQ-005 The block SHALL expose port data_out, output, 4 bits: registered index of the winning request.
REQ-006 The block SHALL expose port valid, output, 1 bit: registered flag, 1 when at least one data_in bit was set.

Function
REQ-007 The block SHALL use one clock domain (clk) and one asynchronous active-high reset (rst).
REQ-008 The encode SHALL be combinational from data_in, implemented as a full 16-way case/casez decode with a default branch.
- The encoded result SHALL be registered into data_out and valid on each rising clk edge.
- Latency SHALL be exactly 1 cycle.
REQ-009 With MSB_PRIORITY=1, data_out SHALL equal the index of the most-significant set bit of data_in.
- Example: 16'b0000_0100_0001_0000 -> 4'd10.
REQ-010 With MSB_PRIORITY=0, data_out SHALL equal the index of the least-significant set bit of data_in.
- Example: 16'b0000_0100_0001_0000 -> 4'd4.
REQ-011 When data_in==16'h0000, the block SHALL register data_out=4'd0 and valid=0.
- This distinguishes the no-request case from "bit 0 only", which gives data_out=4'd0 with valid=1.
REQ-012 When data_in has exactly one bit set, data_out SHALL be that bit's index and valid SHALL be 1, regardless of MSB_PRIORITY.
REQ-013 All bits below the winner (MSB mode), or above the winner (LSB mode), SHALL be don't-care.
- Their value SHALL NOT affect data_out.
REQ-014 data_in SHALL be sampled only at rising clk edges; changes between edges SHALL NOT affect the outputs.
REQ-015 The outputs SHALL never contain X or Z for any known 16-bit data_in once reset has been applied.
REQ-016 The block SHALL hold no state other than the data_out and valid registers.
- No handshake, enable or back-pressure.

Reset
REQ-017 While rst=1, data_out SHALL be 4'd0 and valid SHALL be 0, asynchronously and independent of clk.
REQ-018 Assertion of rst mid-operation SHALL clear the outputs immediately, without waiting for a clk edge.
REQ-019 After rst deasserts, the first rising clk edge SHALL register the encode of the data_in value present at that edge.

Verification
REQ-020 The bench SHALL cover reset:
- rst=1 with data_in=16'hFFFF -> data_out=0, valid=0.
- Deassert rst, then one clk edge -> data_out=15, valid=1 (MSB mode).
REQ-021 The bench SHALL cover zero versus bit 0:
- data_in=16'h0000 -> next cycle data_out=0, valid=0.
- data_in=16'h0001 -> next cycle data_out=0, valid=1.
REQ-022 The bench SHALL cover a one-hot walk:
- data_in=1<<i for i=0..15 -> one cycle later data_out=i, valid=1, in both MSB_PRIORITY settings.
REQ-023 The bench SHALL cover multi-bit priority:
- data_in=16'h8001 -> data_out=15 (MSB=1) or 0 (MSB=0).
- data_in=16'h0410 -> data_out=10 or 4.
REQ-024 The bench SHALL cover an exhaustive sweep:
- Drive all 65536 data_in values, one per cycle.
- Compare each result against a reference-model leading-one/trailing-one index with 1-cycle delay.
- Zero mismatches are required.
REQ-025 The bench SHALL cover asynchronous reset mid-stream:
- Assert rst between clk edges while data_out=12, valid=1.
- Outputs go to 0/0 before the next edge.
- They stay at 0/0 until the first edge after deassertion.
